// File: rtl/reservoir_pkg.sv
// reservoir_pkg: FSM state encoding plus the bipolar-input and clip helpers shared by the reservoir files.
package reservoir_pkg;
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t STEP = 1'b1;

  function automatic int bipolar(input logic b);
    return b ? 1 : -1;
  endfunction

  function automatic int clipVal(input int v, input int c);
    return v > c ? c : (v < -c ? -c : v);
  endfunction
endpackage

// File: rtl/reservoir_cell.sv
// reservoir_cell: one reservoir cell, x' = f(neighbour + bipolar(bit)), clipped with RESERVOIR_SAT_EN or wrapped otherwise.
module reservoir_cell
  import reservoir_pkg::*;
#(
  parameter int DATA_WIDTH = 3,
  parameter int CLIP = 3
) (
  input  logic                         iClk,
  input  logic                         iRst_n,
  input  logic                         iEn,
  input  logic                         iClear,
  input  logic                         iUpd,
  input  logic                         iBit,
  input  logic signed [DATA_WIDTH-1:0] iNeigh,
  output logic signed [DATA_WIDTH-1:0] oState
);
  logic signed [DATA_WIDTH:0] sum;
  logic signed [DATA_WIDTH-1:0] nextState;
  // one guard bit keeps the sum exact before saturation or wrap
  assign sum = {iNeigh[DATA_WIDTH-1], iNeigh} + (DATA_WIDTH+1)'(bipolar(iBit));
`ifdef RESERVOIR_SAT_EN
  assign nextState = DATA_WIDTH'(clipVal(int'(sum), CLIP));
`else
  assign nextState = DATA_WIDTH'(sum);
`endif
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) oState <= '0;
    else if (iEn) oState <= iClear ? '0 : (iUpd ? nextState : oState);
endmodule

// File: rtl/reservoir_core.sv
// reservoir_core: ring of reservoir cells stepped once per accepted word through an IDLE/STEP handshake.
// Define RESERVOIR_SAT_EN to clip cell states to [-CLIP, +CLIP] instead of two's-complement wrap.
module reservoir_core
  import reservoir_pkg::*;
#(
  parameter int RES_SIZE = 3,
  parameter int DATA_WIDTH = 3,
  parameter int CLIP = 3,
  parameter int WASHOUT = 0
) (
  input  logic                           iClk,
  input  logic                           iRst_n,
  input  logic                           iEn,
  input  logic                           iClear,
  input  logic                           iValid,
  input  logic [RES_SIZE-1:0]            iWord,
  output logic                           oReady,
  output logic [DATA_WIDTH*RES_SIZE-1:0] oOut,
  output logic                           oValid,
  output logic                           oWashDone
);
  localparam int CW = $clog2(WASHOUT + 2);
  state_t state;
  logic [RES_SIZE-1:0] word;
  logic [CW-1:0] washCnt;
  logic accept, step;
  logic signed [DATA_WIDTH-1:0] cellState [RES_SIZE];
  assign oReady = state == IDLE;
  assign accept = iEn && iValid && oReady && !iClear;
  assign step = iEn && state == STEP && !iClear;
  assign oWashDone = washCnt == CW'(WASHOUT);
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      state <= IDLE;
      word <= '0;
      washCnt <= '0;
      oValid <= 1'b0;
    end else if (iEn) begin
      state <= iClear ? IDLE : (accept ? STEP : (step ? IDLE : state));
      word <= accept ? iWord : (iClear ? '0 : word);
      washCnt <= iClear ? '0 : (step && !oWashDone ? washCnt + CW'(1) : washCnt);
      oValid <= step && oWashDone;
    end
  // cell 0 closes the ring from the last cell
  for (genvar i = 0; i < RES_SIZE; i++) begin : g_cell
    reservoir_cell #(.DATA_WIDTH(DATA_WIDTH), .CLIP(CLIP)) uCell (
      .iClk(iClk),
      .iRst_n(iRst_n),
      .iEn(iEn),
      .iClear(iClear),
      .iUpd(step),
      .iBit(word[i]),
      .iNeigh(cellState[(i + RES_SIZE - 1) % RES_SIZE]),
      .oState(cellState[i])
    );
    assign oOut[i*DATA_WIDTH +: DATA_WIDTH] = cellState[i];
  end
endmodule
